coherence_bus: RTL and testbench

Bus controller and coherence responder for the dual-core memory system. It sits between the two cores' instruction and data caches and the single RAM port. It arbitrates cache requests and services fetches, write-backs and read misses. On every data read miss it snoops the other core's dcache, and when that cache holds the block dirty it forwards the block cache-to-cache while writing it back to RAM.

---
 rtl/coherence_bus.sv | 175 +++++++++++++++++
 tb/tb_coherence_bus.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus.sv
// Dual-core bus arbiter and snoop responder: grants icache/dcache requests onto
// the single RAM port and forwards dirty blocks cache-to-cache on read misses.
module coherence_bus (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    output logic [1:0][31:0] iload,
    output logic [1:0]       iwait,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    output logic [1:0][31:0] dload,
    output logic [1:0]       dwait,
    input  logic [1:0]       ccwrite,
    input  logic [1:0]       cctrans,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic             ram_ready
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 29;

    typedef enum logic [2:0] {
        IDLE, WB, SNOOP, C2C1, C2C2, RD1, RD2, IFETCH
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic               gnt_c;
    logic               snoop_c;
    logic               g, o;

    // Both cores requesting: the one not served last wins
    function automatic logic pick(input logic [1:0] req, input logic lg);
        if (&req) return ~lg;
        return req[1];
    endfunction

    assign g = grant_q;
    assign o = ~grant_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            blk_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            blk_q        <= blk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        blk_d        = blk_q;
        gnt_c        = 1'b0;
        snoop_c      = 1'b0;
        iload        = '0;
        iwait        = 2'b11;
        dload        = '0;
        dwait        = 2'b11;
        ccwait       = 2'b00;
        ccinv        = 2'b00;
        ccsnoopaddr  = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        unique case (state_q)
            IDLE: begin
                if (|dWEN) begin
                    gnt_c   = pick(dWEN, last_grant_q);
                    state_d = WB;
                end else if (|dREN) begin
                    gnt_c   = pick(dREN, last_grant_q);
                    state_d = SNOOP;
                    blk_d   = daddr[gnt_c][WORD_W-1:3];
                end else if (|iREN) begin
                    gnt_c   = pick(iREN, last_grant_q);
                    state_d = IFETCH;
                end
                if (|{dWEN, dREN, iREN}) begin
                    grant_d      = gnt_c;
                    last_grant_d = gnt_c;
                end
            end
            WB: begin
                if (!dWEN[g]) begin
                    state_d = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[g];
                    ramstore = dstore[g];
                    dwait[g] = ~ram_ready;
                    if (ram_ready) state_d = IDLE;
                end
            end
            SNOOP: begin
                if (!dREN[g]) begin
                    state_d = IDLE;
                end else begin
                    snoop_c = 1'b1;
                    state_d = cctrans[o] ? C2C1 : RD1;
                end
            end
            C2C1, C2C2: begin
                if (!dREN[g]) begin
                    state_d = IDLE;
                end else begin
                    snoop_c = 1'b1;
                    // Second word starts only once the requester asks for offset 4
                    if (state_q == C2C1 || daddr[g][2]) begin
                        ramWEN   = 1'b1;
                        ramaddr  = {blk_q, (state_q == C2C1) ? 3'b000 : 3'b100};
                        ramstore = dstore[o];
                        dload[g] = dstore[o];
                        dwait[g] = ~ram_ready;
                        dwait[o] = ~ram_ready;
                        if (ram_ready) state_d = (state_q == C2C1) ? C2C2 : IDLE;
                    end
                end
            end
            RD1, RD2: begin
                if (!dREN[g]) begin
                    state_d = IDLE;
                end else begin
                    snoop_c = 1'b1;
                    if (state_q == RD1 || daddr[g][2]) begin
                        ramREN   = 1'b1;
                        ramaddr  = daddr[g];
                        dload[g] = ramload;
                        dwait[g] = ~ram_ready;
                        if (ram_ready) state_d = (state_q == RD1) ? RD2 : IDLE;
                    end
                end
            end
            IFETCH: begin
                if (!iREN[g]) begin
                    state_d = IDLE;
                end else begin
                    ramREN   = 1'b1;
                    ramaddr  = iaddr[g];
                    iload[g] = ramload;
                    iwait[g] = ~ram_ready;
                    if (ram_ready) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (snoop_c) begin
            ccwait[o]      = 1'b1;
            ccinv[o]       = ccwrite[g];
            ccsnoopaddr[o] = {blk_q, 3'b000};
        end
    end

endmodule

// File: tb/tb_coherence_bus.sv
// Self-checking bench for coherence_bus: directed scenarios plus randomized
// transactions against a word-array memory model.
module tb_coherence_bus;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0][31:0] iload;
    logic [1:0]       iwait;
    logic [1:0]       dREN, dWEN;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0][31:0] dload;
    logic [1:0]       dwait;
    logic [1:0]       ccwrite, cctrans;
    logic [1:0]       ccwait, ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic             ram_ready;

    coherence_bus dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    // RAM: unwritten words read back as the inverted address
    logic [31:0]   ram_mem [1024];
    logic [1023:0] ram_vld;
    logic          ram_clr;
    always @(posedge CLK) begin
        if (ram_clr) ram_vld <= '0;
        else if (ramWEN && ram_ready) begin
            ram_mem[ramaddr[11:2]] <= ramstore;
            ram_vld[ramaddr[11:2]] <= 1'b1;
        end
    end
    always_comb ramload = ram_vld[ramaddr[11:2]] ? ram_mem[ramaddr[11:2]] : ~ramaddr;

    int both_cnt = 0;
    always @(negedge CLK) if (ramREN && ramWEN) both_cnt++;

    // Reference memory contents and arbitration history
    logic [31:0]   exp_mem [1024];
    logic [1023:0] exp_vld;
    int            lg_m;
    int            n_chk = 0;
    int            n_pass = 0;

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_vld[a[11:2]] ? exp_mem[a[11:2]] : ~a;
    endfunction

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_mem[a[11:2]] = d;
        exp_vld[a[11:2]] = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic samp;
        @(negedge CLK);
    endtask

    task automatic do_write(input int c, input logic [31:0] a, input logic [31:0] d, input int lat);
        dWEN[c] = 1'b1; daddr[c] = a; dstore[c] = d; ram_ready = 1'b0;
        tick;
        repeat (lat) begin
            samp; chk("wr_wait_ramwen", ramWEN, 1); chk("wr_wait_dwait", dwait[c], 1);
            tick;
        end
        ram_ready = 1'b1;
        samp;
        chk("wr_ramwen", ramWEN, 1); chk("wr_ramaddr", ramaddr, a);
        chk("wr_ramstore", ramstore, d); chk("wr_dwait", dwait[c], 0);
        tick;
        dWEN[c] = 1'b0; ram_ready = 1'b0;
        samp; chk("wr_dwait_one_cycle", dwait[c], 1); chk("wr_ramwen_off", ramWEN, 0);
        exp_wr(a, d);
        lg_m = c;
    endtask

    task automatic rd_word(input int c, input logic [31:0] a, input logic dirty,
                           input logic [31:0] d, input int lat);
        int o = 1 - c;
        logic [31:0] e = dirty ? d : exp_rd(a);
        repeat (lat) begin
            samp; chk("rd_wait_dwait", dwait[c], 1); chk("rd_wait_ccwait", ccwait[o], 1);
            tick;
        end
        ram_ready = 1'b1;
        samp;
        chk("rd_dload", dload[c], e); chk("rd_dwait", dwait[c], 0); chk("rd_ramaddr", ramaddr, a);
        if (dirty) begin
            chk("c2c_ramwen", ramWEN, 1); chk("c2c_ramstore", ramstore, d);
            chk("c2c_dwait_src", dwait[o], 0);
            exp_wr(a, d);
        end else begin
            chk("rd_ramren", ramREN, 1);
        end
        tick;
        ram_ready = 1'b0;
    endtask

    task automatic do_read(input int c, input logic [31:0] base, input logic w, input logic dirty,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int lat0, input int lat1, input logic gap);
        int o = 1 - c;
        dREN[c] = 1'b1; daddr[c] = base; ccwrite[c] = w; cctrans[o] = dirty;
        dstore[o] = d0; ram_ready = 1'b0;
        tick;
        samp;
        chk("snp_ccwait", ccwait[o], 1); chk("snp_addr", ccsnoopaddr[o], base);
        chk("snp_inv", ccinv[o], w); chk("snp_not_self", ccwait[c], 0);
        chk("snp_dwait", dwait[c], 1); chk("snp_no_ram", {ramREN, ramWEN}, 0);
        tick;
        rd_word(c, base, dirty, d0, lat0);
        if (gap) begin
            samp;
            chk("gap_dwait", dwait[c], 1); chk("gap_no_ram", {ramREN, ramWEN}, 0);
            chk("gap_ccwait", ccwait[o], 1);
            tick;
        end
        daddr[c] = base + 32'd4; dstore[o] = d1;
        rd_word(c, base + 32'd4, dirty, d1, lat1);
        dREN[c] = 1'b0; cctrans[o] = 1'b0; ccwrite[c] = 1'b0;
        samp;
        chk("rd_ccwait_drop", ccwait[o], 0); chk("rd_ccinv_drop", ccinv[o], 0);
        chk("rd_dwait_idle", dwait[c], 1);
        lg_m = c;
    endtask

    task automatic do_fetch(input int c, input logic [31:0] a, input int lat);
        iREN[c] = 1'b1; iaddr[c] = a; ram_ready = 1'b0;
        tick;
        repeat (lat) begin samp; chk("if_wait", iwait[c], 1); tick; end
        ram_ready = 1'b1;
        samp;
        chk("if_iload", iload[c], exp_rd(a)); chk("if_iwait", iwait[c], 0);
        chk("if_ramren", ramREN, 1);
        tick;
        iREN[c] = 1'b0; ram_ready = 1'b0;
        samp; chk("if_iwait_idle", iwait[c], 1);
        lg_m = c;
    endtask

    task automatic do_tie_fetch(input logic [31:0] a0, input logic [31:0] a1);
        int e = 1 - lg_m;
        iREN = 2'b11; iaddr[0] = a0; iaddr[1] = a1; ram_ready = 1'b0;
        tick;
        ram_ready = 1'b1;
        samp;
        chk("tie_first_iwait", iwait[e], 0); chk("tie_other_iwait", iwait[1-e], 1);
        chk("tie_first_iload", iload[e], exp_rd(iaddr[e]));
        tick;
        iREN[e] = 1'b0; ram_ready = 1'b0;
        tick;
        ram_ready = 1'b1;
        samp;
        chk("tie_second_iwait", iwait[1-e], 0);
        chk("tie_second_iload", iload[1-e], exp_rd(iaddr[1-e]));
        tick;
        iREN = 2'b00; ram_ready = 1'b0;
        lg_m = 1 - e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        ccwrite = '0; cctrans = '0; ram_ready = 1'b0; ram_clr = 1'b1; nRST = 1'b0;
        exp_vld = '0; lg_m = 0;
        tick; tick;
        samp;
        chk("rst_dwait", dwait, 2'b11); chk("rst_iwait", iwait, 2'b11);
        chk("rst_ram", {ramREN, ramWEN}, 0); chk("rst_ccwait", ccwait, 0);
        chk("rst_dload", dload, 0); chk("rst_snoopaddr", ccsnoopaddr, 0);
        ram_clr = 1'b0; nRST = 1'b1;
        tick;

        do_write(0, 32'h100, 32'hDEADBEEF, 1);
        do_write(1, 32'h200, 32'h11, 0);
        do_write(1, 32'h204, 32'h22, 0);
        do_read(0, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1, 1'b0);
        do_read(1, 32'h300, 1'b1, 1'b1, 32'hA, 32'hB, 0, 1, 1'b1);
        do_fetch(0, 32'h300, 0);
        do_fetch(1, 32'h304, 1);
        do_fetch(0, 32'h100, 0);
        do_tie_fetch(32'h200, 32'h204);

        // Store beats fetch
        dWEN[0] = 1'b1; daddr[0] = 32'h400; dstore[0] = 32'h4444; iREN[1] = 1'b1; iaddr[1] = 32'h404;
        tick;
        ram_ready = 1'b1;
        samp;
        chk("pri_ramwen", ramWEN, 1); chk("pri_dwait0", dwait[0], 0); chk("pri_iwait1", iwait[1], 1);
        exp_wr(32'h400, 32'h4444);
        tick;
        dWEN[0] = 1'b0; ram_ready = 1'b0;
        tick;
        ram_ready = 1'b1;
        samp;
        chk("pri_iwait1_later", iwait[1], 0); chk("pri_iload1", iload[1], exp_rd(32'h404));
        tick;
        iREN[1] = 1'b0; ram_ready = 1'b0;
        lg_m = 1;

        // Requester drops its write mid-service
        dWEN[1] = 1'b1; daddr[1] = 32'h600; dstore[1] = 32'h6666;
        tick;
        samp; chk("abort_pre_ramwen", ramWEN, 1);
        dWEN[1] = 1'b0; ram_ready = 1'b1;
        #1; chk("abort_ramwen", ramWEN, 0);
        tick; tick;
        ram_ready = 1'b0;
        do_fetch(0, 32'h600, 0);

        for (int k = 0; k < 24; k++) begin
            int c = int'($urandom_range(0, 1));
            int kind = int'($urandom_range(0, 3));
            logic [31:0] blk = {20'h0, 9'($urandom_range(0, 511)), 3'b000};
            case (kind)
                0: do_write(c, {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom,
                            int'($urandom_range(0, 2)));
                1: do_read(c, blk, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 32'h0,
                           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                           1'($urandom_range(0, 1)));
                2: do_read(c, blk, 1'($urandom_range(0, 1)), 1'b1, $urandom, $urandom,
                           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                           1'($urandom_range(0, 1)));
                default: do_fetch(c, {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                                  int'($urandom_range(0, 2)));
            endcase
        end
        do_tie_fetch(32'h300, 32'h100);

        // Reset during the first cache-to-cache word
        dREN[0] = 1'b1; daddr[0] = 32'h500; cctrans[1] = 1'b1; dstore[1] = 32'h5555;
        tick; tick;
        samp; chk("c2c_pre_rst_ramwen", ramWEN, 1);
        #1; nRST = 1'b0;
        #1;
        chk("rstmid_ramwen", ramWEN, 0); chk("rstmid_dwait", dwait, 2'b11);
        chk("rstmid_ccwait", ccwait, 0); chk("rstmid_ramaddr", ramaddr, 0);
        chk("rstmid_ramstore", ramstore, 0); chk("rstmid_dload", dload, 0);
        dREN[0] = 1'b0; cctrans[1] = 1'b0; ram_ready = 1'b1;
        tick; tick;
        nRST = 1'b1;
        samp; chk("post_rst_ramwen", ramWEN, 0);
        tick;
        samp; chk("post_rst_ramwen2", ramWEN, 0);
        ram_ready = 1'b0;
        lg_m = 0;
        do_fetch(1, 32'h500, 0);
        do_tie_fetch(32'h504, 32'h500);

        chk("ren_wen_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
